seq_divider: RTL and testbench

Sequential restoring divider, the inverse of the team's combinational 6x6 array multiplier. It takes a DW-bit dividend (a product-width operand) and a VW-bit divisor, and returns a DW-bit quotient and a VW-bit remainder. It resolves one quotient bit per clock. Valid/ready handshakes on both the input and output sides let it sit between the tile pin interface and the downstream datapath.

---
 rtl/seq_divider_if.sv | 28 ++
 rtl/seq_divider.sv | 114 +++++++++++
 tb/tb_seq_divider.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Handshake bundle for the sequential divider: operand request channel
// (dividend/divisor) and result response channel (quotient/remainder).
interface seq_divider_if #(
    parameter int DW = 12,
    parameter int VW = 6
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    // Producer of operands / consumer of results
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    // The divider itself
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, DW iterations.
// Results are copied into dedicated output registers on entry to DONE so they
// stay valid after the handshake even when a new operation is accepted.
module seq_divider #(
    parameter int DW = 12,
    parameter int VW = 6
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;

    // Working registers: Q doubles as the dividend shift register
    logic [DW-1:0] q_reg;
    logic [VW-1:0] r_reg;
    logic [VW-1:0] d_reg;
    logic [CW-1:0] cnt_reg;
    logic          dbz_reg;

    // Presented result
    logic [DW-1:0] quo_reg;
    logic [VW-1:0] rem_reg;
    logic          dbz_out_reg;

    // One restoring step
    logic [VW:0]   trial;
    logic          fits;
    logic [VW-1:0] r_step;
    logic [DW-1:0] q_step;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        trial  = {r_reg, q_reg[DW-1]};
        fits   = (trial >= {1'b0, d_reg});
        r_step = fits ? VW'(trial - {1'b0, d_reg}) : trial[VW-1:0];
        q_step = {q_reg[DW-2:0], fits};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode; in_ready is implied by being in IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid)     state_next = RUN;
            RUN:     if (cnt_reg == '0)    state_next = DONE;
            DONE:    if (bus.out_ready)    state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg       <= '0;
            r_reg       <= '0;
            d_reg       <= '0;
            cnt_reg     <= '0;
            dbz_reg     <= 1'b0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            dbz_out_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        q_reg   <= bus.dividend;
                        d_reg   <= bus.divisor;
                        r_reg   <= '0;
                        cnt_reg <= CW'(DW - 1);
                        dbz_reg <= (bus.divisor == '0);
                    end
                end
                RUN: begin
                    q_reg <= q_step;
                    r_reg <= r_step;
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        // Final step: publish result, forcing the divide-by-zero form
                        quo_reg     <= dbz_reg ? {DW{1'b1}} : q_step;
                        rem_reg     <= dbz_reg ? '0 : r_step;
                        dbz_out_reg <= dbz_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state_reg == IDLE);
    assign bus.out_valid   = (state_reg == DONE);
    assign bus.quotient    = quo_reg;
    assign bus.remainder   = rem_reg;
    assign bus.div_by_zero = dbz_out_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver pushes the expected result of
// every accepted operation; a negedge monitor checks handshake timing and
// compares presented results against the queue front.
module tb_seq_divider;
    localparam int DW = 12;
    localparam int VW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   rand_ready = 1'b0;

    typedef struct {
        int          a;
        int          b;
        logic [11:0] q;
        logic [5:0]  r;
        logic        dbz;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    seq_divider_if #(.DW(DW), .VW(VW)) bus();

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer division, divide-by-zero yields all ones / 0
    function automatic exp_t model(input int a, input int b, input int acc);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.acc = acc;
        if (b == 0) begin
            e.q   = 12'hFFF;
            e.r   = 6'd0;
            e.dbz = 1'b1;
        end else begin
            e.q   = 12'(a / b);
            e.r   = 6'(a % b);
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Present an operation; waits (bounded) for in_ready, records expectation
    task automatic send(input int a, input int b, input bit keep);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.dividend = 12'(a);
        bus.divisor  = 6'(b);
        while (!bus.in_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
        end else begin
            exp_q.push_back(model(a, b, cyc + 1));
            $display("issue %0d / %0d accepted at edge %0d", a, b, cyc + 1);
        end
        @(posedge clk); #1;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Random consumer backpressure
    always @(posedge clk) begin
        #1;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: handshake timing and result comparison, away from the active edge
    always @(negedge clk) begin : monitor
        bit busy;
        bit ev;
        exp_t e;
        if (!rst) begin
            busy = (exp_q.size() > 0) && (cyc >= exp_q[0].acc);
            ev   = busy && (cyc >= exp_q[0].acc + DW);
            chk("in_ready", 32'(bus.in_ready), 32'(!busy));
            chk("out_valid", 32'(bus.out_valid), 32'(ev));
            if (ev) begin
                e = exp_q[0];
                chk("quotient", 32'(bus.quotient), 32'(e.q));
                chk("remainder", 32'(bus.remainder), 32'(e.r));
                chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
                if (e.b != 0) begin
                    chk("identity", 32'(int'(bus.quotient) * e.b + int'(bus.remainder)), 32'(e.a));
                    chk("rem_lt_div", 32'(int'(bus.remainder) < e.b), 32'd1);
                end
                if (bus.out_ready) begin
                    $display("result %0d / %0d -> q=%0d r=%0d dbz=%0d at cycle %0d",
                             e.a, e.b, bus.quotient, bus.remainder, bus.div_by_zero, cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_quotient"}, 32'(bus.quotient), 32'd0);
        chk({tag, "_remainder"}, 32'(bus.remainder), 32'd0);
        chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'd0);
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic and multiplier-inverse cases
        send(100, 7, 0);    wait_idle();
        send(4095, 63, 0);  wait_idle();
        send(3970, 63, 0);  wait_idle();
        send(0, 5, 0);      wait_idle();

        // Divide by zero followed by a normal op
        send(1234, 0, 0);   wait_idle();
        send(50, 5, 0);     wait_idle();

        // Backpressure: hold result, stray in_valid must be ignored
        bus.out_ready = 1'b0;
        send(200, 9, 0);
        bus.in_valid = 1'b1;
        bus.dividend = 12'd999;
        bus.divisor  = 6'd1;
        repeat (DW + 5) begin @(posedge clk); #1; end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle();

        // Reset in the middle of an operation
        send(4000, 3, 0);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        rst = 1'b0;
        send(4000, 3, 0);   wait_idle();

        // Back-to-back with in_valid held high
        send(9, 2, 1);
        send(63, 63, 1);
        send(12, 13, 0);
        wait_idle();

        // Random sweep over every non-zero divisor with random backpressure
        rand_ready = 1'b1;
        for (int b = 1; b < 64; b++) begin
            send(int'($urandom_range(0, 4095)), b, 0);
        end
        for (int i = 0; i < 20; i++) begin
            send(int'($urandom_range(0, 4095)), int'($urandom_range(0, 63)), 0);
        end
        wait_idle();
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
